// File: rtl/vga_timing_controller.sv
// VGA raster generator: pixel tick, h/v counters, sync pulses, display-active flag, line/frame strobes.
// Optional FRAME_COUNTER_EN adds an 8-bit frameCount output counting completed frames.
module vga_timing_controller #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned SYNC_ACT_LO = 1
) (
    input  logic       clk,
    input  logic       resetN,
    output logic       pixTick,
    output logic [9:0] horizCount,
    output logic [9:0] vertCount,
    output logic       hsync,
    output logic       vsync,
    output logic       displayActive,
    output logic       lineStart,
    output logic       frameStart
`ifdef FRAME_COUNTER_EN
    ,
    output logic [7:0] frameCount
`endif
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic             SYNC_OFF = (SYNC_ACT_LO != 0);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [CNT_W-1:0] h_d;
    logic [CNT_W-1:0] v_d;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_d;
    logic             vs_d;
    logic             da_d;
`ifdef FRAME_COUNTER_EN
    logic [7:0]       fc_d;
`endif

    // Next-state: sync/active are decoded from the next counts so they align with the counters.
    always_comb begin
        tick   = (div_q == DIV_LAST);
        h_wrap = tick && (horizCount == H_LAST);
        v_wrap = h_wrap && (vertCount == V_LAST);
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        h_d    = horizCount;
        v_d    = vertCount;
        if (tick) begin
            h_d = h_wrap ? '0 : horizCount + CNT_W'(1);
        end
        if (h_wrap) begin
            v_d = v_wrap ? '0 : vertCount + CNT_W'(1);
        end
        hs_d = SYNC_OFF ^ ((h_d >= HS_BEG) && (h_d < HS_END));
        vs_d = SYNC_OFF ^ ((v_d >= VS_BEG) && (v_d < VS_END));
        da_d = (h_d < H_VIS) && (v_d < V_VIS);
`ifdef FRAME_COUNTER_EN
        fc_d = v_wrap ? frameCount + 8'(1) : frameCount;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            div_q         <= '0;
            horizCount    <= '0;
            vertCount     <= '0;
            pixTick       <= 1'b0;
            hsync         <= SYNC_OFF;
            vsync         <= SYNC_OFF;
            displayActive <= 1'b0;
            lineStart     <= 1'b0;
            frameStart    <= 1'b0;
`ifdef FRAME_COUNTER_EN
            frameCount    <= '0;
`endif
        end else begin
            div_q         <= div_d;
            horizCount    <= h_d;
            vertCount     <= v_d;
            pixTick       <= tick;
            hsync         <= hs_d;
            vsync         <= vs_d;
            displayActive <= da_d;
            lineStart     <= h_wrap;
            frameStart    <= v_wrap;
`ifdef FRAME_COUNTER_EN
            frameCount    <= fc_d;
`endif
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: default-timing DUT (a), small CLK_DIV=2 raster (b), CLK_DIV=1 active-high raster (c).
module tb_vga_timing_controller;

    typedef struct packed {
        logic       pt;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       da;
        logic       ls;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic       pt_a, hs_a, vs_a, da_a, ls_a, fs_a;
    logic       pt_b, hs_b, vs_b, da_b, ls_b, fs_b;
    logic       pt_c, hs_c, vs_c, da_c, ls_c, fs_c;
    logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
`ifdef FRAME_COUNTER_EN
    logic [7:0] fc_a, fc_b, fc_c;
`endif

    logic [26:0] obs_a, obs_b, obs_c;
    assign obs_a = {pt_a, h_a, v_a, hs_a, vs_a, da_a, ls_a, fs_a};
    assign obs_b = {pt_b, h_b, v_b, hs_b, vs_b, da_b, ls_b, fs_b};
    assign obs_c = {pt_c, h_c, v_c, hs_c, vs_c, da_c, ls_c, fs_c};

    int n_a = 0, n_b = 0, n_c = 0;
    int cmp_n = 0, err_n = 0;

    vga_timing_controller dut_a (
        .clk(clk), .resetN(rst_a), .pixTick(pt_a), .horizCount(h_a), .vertCount(v_a),
        .hsync(hs_a), .vsync(vs_a), .displayActive(da_a), .lineStart(ls_a), .frameStart(fs_a)
`ifdef FRAME_COUNTER_EN
        , .frameCount(fc_a)
`endif
    );

    vga_timing_controller #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACT_LO(1)
    ) dut_b (
        .clk(clk), .resetN(rst_b), .pixTick(pt_b), .horizCount(h_b), .vertCount(v_b),
        .hsync(hs_b), .vsync(vs_b), .displayActive(da_b), .lineStart(ls_b), .frameStart(fs_b)
`ifdef FRAME_COUNTER_EN
        , .frameCount(fc_b)
`endif
    );

    vga_timing_controller #(
        .CLK_DIV(1), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACT_LO(0)
    ) dut_c (
        .clk(clk), .resetN(rst_c), .pixTick(pt_c), .horizCount(h_c), .vertCount(v_c),
        .hsync(hs_c), .vsync(vs_c), .displayActive(da_c), .lineStart(ls_c), .frameStart(fs_c)
`ifdef FRAME_COUNTER_EN
        , .frameCount(fc_c)
`endif
    );

    // Reference raster: n = clk edges since reset release (0 = in reset).
    function automatic exp_t model(int n, int div, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, bit actlo);
        exp_t e;
        int   ticks, ht, vt, h, v;
        ht    = hv + hf + hsw + hb;
        vt    = vv + vf + vsw + vb;
        ticks = n / div;
        h     = ticks % ht;
        v     = (ticks / ht) % vt;
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.pt  = (n > 0) && (n % div == 0);
        e.hs  = actlo ^ ((n > 0) && (h >= hv + hf) && (h < hv + hf + hsw));
        e.vs  = actlo ^ ((n > 0) && (v >= vv + vf) && (v < vv + vf + vsw));
        e.da  = (n > 0) && (h < hv) && (v < vv);
        e.ls  = e.pt && (h == 0);
        e.fs  = e.ls && (v == 0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        n_a = rst_a ? n_a + 1 : 0;
        n_b = rst_b ? n_b + 1 : 0;
        n_c = rst_c ? n_c + 1 : 0;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (3) step();
        e = model(0, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
        cmp_n++;
        if (obs_a !== 27'(e)) begin
            err_n++; $display("FAIL reset_a got %h want %h", obs_a, 27'(e));
        end
        e = model(0, 2, 8, 2, 3, 3, 6, 1, 2, 1, 1'b1);
        cmp_n++;
        if (obs_b !== 27'(e)) begin
            err_n++; $display("FAIL reset_b got %h want %h", obs_b, 27'(e));
        end
        cmp_n++;
        if ({hs_c, vs_c, pt_c, da_c, ls_c, fs_c, h_c, v_c} !== 26'd0) begin
            err_n++; $display("FAIL reset_c got %b%b%b%b%b%b h=%0d v=%0d want all zero",
                              hs_c, vs_c, pt_c, da_c, ls_c, fs_c, h_c, v_c);
        end
    endtask

    task automatic test_release();
        logic       pt_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [9:0] h_tab  [4] = '{10'd0, 10'd1, 10'd1, 10'd2};
        rst_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            cmp_n++;
            if ({pt_a, h_a, da_a} !== {pt_tab[i], h_tab[i], 1'b1}) begin
                err_n++; $display("FAIL release_clk%0d got pt=%b h=%0d da=%b want pt=%b h=%0d da=1",
                                  i + 1, pt_a, h_a, da_a, pt_tab[i], h_tab[i]);
            end
        end
    endtask

    task automatic test_hsync();
        int         n_tab  [6] = '{1278, 1280, 1311, 1312, 1502, 1504};
        logic [9:0] h_tab  [6] = '{10'd639, 10'd640, 10'd655, 10'd656, 10'd751, 10'd752};
        logic       hs_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       da_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            while (n_a < n_tab[i]) step();
            cmp_n++;
            if ({h_a, hs_a, vs_a, da_a} !== {h_tab[i], hs_tab[i], 1'b1, da_tab[i]}) begin
                err_n++; $display("FAIL hsync_pt%0d got h=%0d hs=%b vs=%b da=%b want h=%0d hs=%b vs=1 da=%b",
                                  i, h_a, hs_a, vs_a, da_a, h_tab[i], hs_tab[i], da_tab[i]);
            end
        end
    endtask

    task automatic test_line_wrap();
        while (n_a < 1598) step();
        cmp_n++;
        if ({h_a, v_a, ls_a} !== {10'd799, 10'd0, 1'b0}) begin
            err_n++; $display("FAIL line_end got h=%0d v=%0d ls=%b want 799 0 0", h_a, v_a, ls_a);
        end
        while (n_a < 1600) step();
        cmp_n++;
        if ({h_a, v_a, ls_a, fs_a, pt_a} !== {10'd0, 10'd1, 1'b1, 1'b0, 1'b1}) begin
            err_n++; $display("FAIL line_wrap got h=%0d v=%0d ls=%b fs=%b pt=%b want 0 1 1 0 1",
                              h_a, v_a, ls_a, fs_a, pt_a);
        end
        step();
        cmp_n++;
        if ({h_a, v_a, ls_a} !== {10'd0, 10'd1, 1'b0}) begin
            err_n++; $display("FAIL line_strobe_len got h=%0d v=%0d ls=%b want 0 1 0", h_a, v_a, ls_a);
        end
    endtask

    task automatic test_sweep_a();
        exp_t e;
        while (n_a < 3300) begin
            step();
            e = model(n_a, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
            cmp_n++;
            if (obs_a !== 27'(e)) begin
                err_n++; $display("FAIL sweep_a n=%0d got %h want %h", n_a, obs_a, 27'(e));
            end
        end
    endtask

    task automatic test_frame_wrap();
        exp_t e;
        rst_b = 1'b1;
        while (n_b < 700) begin
            step();
            e = model(n_b, 2, 8, 2, 3, 3, 6, 1, 2, 1, 1'b1);
            cmp_n++;
            if (obs_b !== 27'(e)) begin
                err_n++; $display("FAIL sweep_b n=%0d got %h want %h", n_b, obs_b, 27'(e));
            end
            if (n_b == 224) begin
                cmp_n++;
                if ({h_b, v_b, vs_b} !== {10'd0, 10'd7, 1'b0}) begin
                    err_n++; $display("FAIL vsync_start got h=%0d v=%0d vs=%b want 0 7 0", h_b, v_b, vs_b);
                end
            end
            if (n_b == 320) begin
                cmp_n++;
                if ({h_b, v_b, ls_b, fs_b} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
                    err_n++; $display("FAIL frame_wrap got h=%0d v=%0d ls=%b fs=%b want 0 0 1 1",
                                      h_b, v_b, ls_b, fs_b);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [26:0] rst_vec;
        rst_vec = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        while (n_b < 107) step();
        cmp_n++;
        if ({h_b, v_b} !== {10'd5, 10'd3}) begin
            err_n++; $display("FAIL mid_pos got h=%0d v=%0d want 5 3", h_b, v_b);
        end
        rst_b = 1'b0;
        step();
        cmp_n++;
        if (obs_b !== rst_vec) begin
            err_n++; $display("FAIL mid_reset got %h want %h", obs_b, rst_vec);
        end
        rst_b = 1'b1;
        step();
        cmp_n++;
        if ({pt_b, h_b, v_b, da_b, ls_b} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b0}) begin
            err_n++; $display("FAIL mid_rel1 got pt=%b h=%0d v=%0d da=%b ls=%b want 0 0 0 1 0",
                              pt_b, h_b, v_b, da_b, ls_b);
        end
        step();
        cmp_n++;
        if ({pt_b, h_b, ls_b} !== {1'b1, 10'd1, 1'b0}) begin
            err_n++; $display("FAIL mid_rel2 got pt=%b h=%0d ls=%b want 1 1 0", pt_b, h_b, ls_b);
        end
        while (n_b < 319) step();
        cmp_n++;
        if ({h_b, v_b} !== {10'd15, 10'd9}) begin
            err_n++; $display("FAIL pre_wrap got h=%0d v=%0d want 15 9", h_b, v_b);
        end
        rst_b = 1'b0;
        step();
        cmp_n++;
        if (obs_b !== rst_vec) begin
            err_n++; $display("FAIL wrap_reset got %h want %h", obs_b, rst_vec);
        end
        rst_b = 1'b1;
    endtask

    task automatic test_clkdiv1();
        exp_t e;
        int   last_n;
`ifdef FRAME_COUNTER_EN
        last_n = 8232;
`else
        last_n = 100;
`endif
        rst_c = 1'b1;
        while (n_c < last_n) begin
            step();
            e = model(n_c, 1, 4, 1, 2, 1, 1, 1, 1, 1, 1'b0);
            cmp_n++;
            if (obs_c !== 27'(e)) begin
                err_n++; $display("FAIL sweep_c n=%0d got %h want %h", n_c, obs_c, 27'(e));
            end
`ifdef FRAME_COUNTER_EN
            cmp_n++;
            if (fc_c !== 8'((n_c / 32) % 256)) begin
                err_n++; $display("FAIL frame_count n=%0d got %0d want %0d", n_c, fc_c, (n_c / 32) % 256);
            end
            if (n_c == 8192) begin
                cmp_n++;
                if ({fc_c, fs_c} !== {8'd0, 1'b1}) begin
                    err_n++; $display("FAIL frame_count_wrap got fc=%0d fs=%b want 0 1", fc_c, fs_c);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_hsync();
        test_line_wrap();
        test_sweep_a();
        test_frame_wrap();
        test_reset_mid();
        test_clkdiv1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
